// File: rtl/set_less_arbiter_if.sv
// Request/response bundle for the shared less-than comparator arbiter.
// The arbiter side uses the slave modport; requesters/consumer use master.
interface set_less_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    i_ReqValid;
  logic [NUM_REQ-1:0]    o_ReqReady;
  logic [NUM_REQ*32-1:0] i_ReqA;
  logic [NUM_REQ*32-1:0] i_ReqB;
  logic [NUM_REQ-1:0]    i_ReqUnsigned;
  logic                  i_Flush;
  logic                  o_RespValid;
  logic                  i_RespReady;
  logic [ID_W-1:0]       o_RespId;
  logic [31:0]           o_RespResult;
  logic [15:0]           o_ConflictCount;

  modport slave (
    input  i_ReqValid, i_ReqA, i_ReqB, i_ReqUnsigned, i_Flush, i_RespReady,
    output o_ReqReady, o_RespValid, o_RespId, o_RespResult, o_ConflictCount
  );

  modport master (
    output i_ReqValid, i_ReqA, i_ReqB, i_ReqUnsigned, i_Flush, i_RespReady,
    input  o_ReqReady, o_RespValid, o_RespId, o_RespResult, o_ConflictCount
  );
endinterface

// File: rtl/set_less_arbiter.sv
// Round-robin arbiter sharing one 32-bit signed/unsigned less-than compare
// between NUM_REQ requesters, with a single-entry registered result buffer.
module set_less_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_ResetN,
  set_less_arbiter_if.slave    bus
);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     resp_id_q, resp_id_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    conflict_q, conflict_d;

  logic                can_accept;
  logic                grant_any;
  logic [ID_W-1:0]     gnt_idx;
  logic [ID_W-1:0]     cand;
  logic [NUM_REQ-1:0]  req_ready;
  logic [DATA_W-1:0]   op_a, op_b;
  logic                op_uns;
  logic                lt_bit;

  function automatic logic less_than(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic uns);
    logic signed [DATA_W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (uns) return (a < b);
    return (sa < sb);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Grant: first valid requester at or after the round-robin pointer.
  always_comb begin
    can_accept = i_ResetN & ~bus.i_Flush & ((state_q == EMPTY) | bus.i_RespReady);
    grant_any  = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (can_accept && !grant_any && bus.i_ReqValid[cand]) begin
        grant_any = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (grant_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_uns = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == ID_W'(k)) begin
        op_a   = bus.i_ReqA[k*DATA_W +: DATA_W];
        op_b   = bus.i_ReqB[k*DATA_W +: DATA_W];
        op_uns = bus.i_ReqUnsigned[k];
      end
    end
    lt_bit = less_than(op_a, op_b, op_uns);
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    resp_id_d  = resp_id_q;
    result_d   = result_q;
    conflict_d = ($countones(bus.i_ReqValid) > 1) ? sat_inc(conflict_q) : conflict_q;
    // Flush beats both the consumer handshake and any pending grant.
    if (bus.i_Flush) begin
      state_d = EMPTY;
    end else if (grant_any) begin
      state_d   = FULL;
      resp_id_d = gnt_idx;
      result_d  = {{(DATA_W-1){1'b0}}, lt_bit};
      ptr_d     = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end else if (state_q == FULL && bus.i_RespReady) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge i_Clock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      resp_id_q  <= '0;
      result_q   <= '0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      resp_id_q  <= resp_id_d;
      result_q   <= result_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.o_ReqReady      = req_ready;
  assign bus.o_RespValid     = (state_q == FULL);
  assign bus.o_RespId        = resp_id_q;
  assign bus.o_RespResult    = result_q;
  assign bus.o_ConflictCount = conflict_q;
endmodule

// File: tb/tb_set_less_arbiter.sv
// Bench for set_less_arbiter: directed vectors, literal expectations and a
// cycle-by-cycle behavioural model of the buffer, grant order and counter.
module tb_set_less_arbiter;
  localparam int NUM_REQ = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  set_less_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  set_less_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .i_Clock  (clk),
    .i_ResetN (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: buffer occupancy, owner, result, pointer, counter.
  logic        m_full;
  int          m_id;
  logic [31:0] m_res;
  int          m_ptr;
  int          m_cnt;

  function automatic logic model_lt(input logic [31:0] a, input logic [31:0] b, input logic uns);
    if (uns) return a < b;
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  initial begin
    m_full = 1'b0; m_id = 0; m_res = '0; m_ptr = 0; m_cnt = 0;
  end

  always @(negedge clk) begin
    logic            can;
    int              win;
    logic [NUM_REQ-1:0] exp_ready;
    if (!rst_n) begin
      m_full = 1'b0; m_id = 0; m_res = '0; m_ptr = 0; m_cnt = 0;
    end
    chk("model_resp_valid", 32'(bus.o_RespValid), 32'(m_full));
    chk("model_resp_id", 32'(bus.o_RespId), 32'(m_id));
    chk("model_resp_result", bus.o_RespResult, m_res);
    chk("model_conflict", 32'(bus.o_ConflictCount), 32'(m_cnt));
    can = rst_n && !bus.i_Flush && (!m_full || bus.i_RespReady);
    win = -1;
    if (can) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int c;
        c = (m_ptr + i) % NUM_REQ;
        if (win < 0 && bus.i_ReqValid[c]) win = c;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("model_req_ready", 32'(bus.o_ReqReady), 32'(exp_ready));
    if (rst_n) begin
      if ($countones(bus.i_ReqValid) > 1 && m_cnt < 65535) m_cnt++;
      if (bus.i_Flush) m_full = 1'b0;
      else if (win >= 0) begin
        m_full = 1'b1;
        m_id   = win;
        m_res  = {31'b0, model_lt(bus.i_ReqA[win*32 +: 32], bus.i_ReqB[win*32 +: 32],
                                  bus.i_ReqUnsigned[win])};
        m_ptr  = (win + 1) % NUM_REQ;
      end else if (m_full && bus.i_RespReady) m_full = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n = 1'b0;
    bus.i_ReqValid = 2'b01; bus.i_ReqA = '0; bus.i_ReqB = '0;
    bus.i_ReqUnsigned = '0; bus.i_Flush = 1'b0; bus.i_RespReady = 1'b1;
    tick();
    chk("rst_ready", 32'(bus.o_ReqReady), 32'h0);
    chk("rst_valid", 32'(bus.o_RespValid), 32'h0);
    chk("rst_count", 32'(bus.o_ConflictCount), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.i_ReqValid = '0;
    tick();

    // Signedness
    bus.i_ReqValid = 2'b01;
    bus.i_ReqA = {32'd0, 32'hFFFF_FFFF}; bus.i_ReqB = {32'd0, 32'd1}; bus.i_ReqUnsigned = 2'b00;
    @(negedge clk); chk("sgn_ready", 32'(bus.o_ReqReady), 32'h1);
    tick();
    chk("sgn_valid", 32'(bus.o_RespValid), 32'h1);
    chk("sgn_result", bus.o_RespResult, 32'h1);
    chk("sgn_id", 32'(bus.o_RespId), 32'h0);
    bus.i_ReqUnsigned = 2'b01;
    tick();
    chk("uns_result", bus.o_RespResult, 32'h0);
    bus.i_ReqA = {32'd0, 32'd5}; bus.i_ReqB = {32'd0, 32'd5}; bus.i_ReqUnsigned = 2'b00;
    tick();
    chk("eq_result", bus.o_RespResult, 32'h0);
    bus.i_ReqValid = '0;
    tick();
    chk("drain_valid", 32'(bus.o_RespValid), 32'h0);

    // Contention from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_ReqA = {32'd9, 32'd3}; bus.i_ReqB = {32'd2, 32'd7}; bus.i_ReqUnsigned = 2'b11;
    bus.i_ReqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("cont_ready", 32'(bus.o_ReqReady), (k % 2) ? 32'h2 : 32'h1);
      tick();
      chk("cont_id", 32'(bus.o_RespId), 32'(k % 2));
      chk("cont_result", bus.o_RespResult, (k % 2) ? 32'h0 : 32'h1);
    end
    bus.i_ReqValid = '0;
    tick();
    chk("cont_count", 32'(bus.o_ConflictCount), 32'd4);

    // Backpressure
    bus.i_ReqValid = 2'b01; bus.i_RespReady = 1'b0;
    tick();
    chk("bp_fill_id", 32'(bus.o_RespId), 32'h0);
    bus.i_ReqValid = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("bp_ready", 32'(bus.o_ReqReady), 32'h0);
      tick();
      chk("bp_hold_id", 32'(bus.o_RespId), 32'h0);
      chk("bp_hold_result", bus.o_RespResult, 32'h1);
    end
    bus.i_RespReady = 1'b1;
    @(negedge clk); chk("bp_release_ready", 32'(bus.o_ReqReady), 32'h2);
    tick();
    chk("bp_release_id", 32'(bus.o_RespId), 32'h1);
    chk("bp_release_result", bus.o_RespResult, 32'h0);

    // Flush
    bus.i_ReqValid = 2'b01; bus.i_Flush = 1'b1;
    @(negedge clk); chk("flush_ready", 32'(bus.o_ReqReady), 32'h0);
    tick();
    chk("flush_valid", 32'(bus.o_RespValid), 32'h0);
    bus.i_Flush = 1'b0; bus.i_ReqValid = 2'b11;
    @(negedge clk); chk("reissue_ready", 32'(bus.o_ReqReady), 32'h1);
    tick();
    chk("reissue_id", 32'(bus.o_RespId), 32'h0);
    chk("reissue_valid", 32'(bus.o_RespValid), 32'h1);

    // Reset mid-operation
    bus.i_ReqValid = 2'b10;
    tick();
    chk("pre_rst_id", 32'(bus.o_RespId), 32'h1);
    bus.i_ReqValid = 2'b11; bus.i_RespReady = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.o_RespValid), 32'h0);
    chk("async_id", 32'(bus.o_RespId), 32'h0);
    chk("async_result", bus.o_RespResult, 32'h0);
    chk("async_count", 32'(bus.o_ConflictCount), 32'h0);
    chk("async_ready", 32'(bus.o_ReqReady), 32'h0);
    tick();
    rst_n = 1'b1; bus.i_RespReady = 1'b1;
    @(negedge clk); chk("post_rst_ready", 32'(bus.o_ReqReady), 32'h1);
    tick();
    chk("post_rst_id", 32'(bus.o_RespId), 32'h0);

    // Saturation
    repeat (65540) tick();
    chk("sat_count", 32'(bus.o_ConflictCount), 32'h0000_FFFF);
    tick();
    chk("sat_hold", 32'(bus.o_ConflictCount), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/set_less_arbiter.md
# set_less_arbiter

Round-robin arbiter and sequencer that shares one signed/unsigned 32-bit less-than comparator between up to four requesters. Typical requesters are the branch-resolution unit (BLT/BGE/BLTU/BGEU) and the ALU SLT/SLTU/SLTI/SLTIU path. It accepts one compare per cycle, registers the result in a single-entry output buffer with valid/ready backpressure, and supports a pipeline flush. It counts contention cycles for performance monitoring.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- ID_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

- i_Clock  in  1  rising-edge clock
- i_ResetN  in  1  asynchronous, active-low reset
- i_ReqValid  in  NUM_REQ  bit k: requester k presents a compare
- o_ReqReady  out  NUM_REQ  bit k: requester k's compare accepted this cycle (one-hot or zero)
- i_ReqA  in  NUM_REQ*32  operand A, requester k at bits [32k+31:32k]
- i_ReqB  in  NUM_REQ*32  operand B, same packing
- i_ReqUnsigned  in  NUM_REQ  bit k: 1 = unsigned compare, 0 = signed
- i_Flush  in  1  discard buffered result and block acceptance this cycle
- o_RespValid  out  1  result buffer holds a result
- i_RespReady  in  1  consumer takes the result this cycle
- o_RespId  out  ID_W  index of the requester that owns the result
- o_RespResult  out  32  32'h0000_0001 if A<B under the selected signedness, else 32'h0000_0000
- o_ConflictCount  out  16  saturating count of cycles with >1 request valid

## Operation
- Buffer FSM, two states: EMPTY (o_RespValid=0), FULL (o_RespValid=1).
- Can-accept condition: i_ResetN=1, i_Flush=0, and (EMPTY or (FULL and i_RespReady=1)).
- Grant: when can-accept holds and any i_ReqValid bit is set, pick the first valid requester scanning P, P+1, ... mod NUM_REQ, where P is the round-robin pointer. Assert only that o_ReqReady bit. o_ReqReady depends combinationally on i_ReqValid, i_Flush, i_RespReady, P and the state.
- Compare on grant: unsigned compare uses A<B on raw bits; signed compare uses two's-complement A<B. Result is zero-extended to 32 bits. Operands are not registered; the result is registered.
- On grant: load o_RespId=k and o_RespResult, go to FULL, and set P=(k+1) mod NUM_REQ. P changes only on a grant.
- FULL with i_RespReady=1 and no grant: go to EMPTY. o_RespId and o_RespResult keep their last values.
- FULL with i_RespReady=1 and a grant in the same cycle: stay FULL with the new result (back-to-back throughput).
- FULL with i_RespReady=0: hold all outputs stable, o_ReqReady=0.
- i_Flush=1: next state EMPTY regardless of i_RespReady, no grant that cycle, P unchanged. The flushed entry is not counted as consumed.
- o_ConflictCount: increments each cycle with popcount(i_ReqValid)>1, independent of can-accept and flush. Saturates at 16'hFFFF.
- Requesters must hold A, B and Unsigned stable while valid and not ready. The block does not check this.

## Timing
- Latency: a request accepted in cycle N gives o_RespValid=1 with its result in cycle N+1.
- Throughput: one compare per cycle while i_RespReady stays 1.
- Reset (i_ResetN=0) is asynchronous and takes effect immediately, including mid-transaction. The state goes to EMPTY and the buffered result is lost.
- Values held during reset: o_RespValid=0, o_RespId=0, o_RespResult=0, P=0, o_ConflictCount=0, o_ReqReady=0.
- First grant after reset: requester 0 wins if valid.
- Under full contention with the consumer always ready, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 grants.
- Simultaneous i_Flush and i_RespReady: flush wins, and the consumer's handshake is ignored.
- Simultaneous request and flush: the request is not accepted and must be re-presented.

## Test plan
- Signedness, NUM_REQ=2: req0 A=32'hFFFF_FFFF, B=1, Unsigned=0, then Unsigned=1, with i_RespReady=1 -> o_RespResult=1 then 0, each one cycle after accept, o_RespId=0. Equal operands A=B=5 -> 0.
- Contention: after reset, hold both i_ReqValid=2'b11 for 4 cycles with i_RespReady=1 -> o_ReqReady is 01,10,01,10, o_RespId is 0,1,0,1, and o_ConflictCount=4.
- Backpressure: fill the buffer, hold i_RespReady=0 for 3 cycles with req1 valid -> o_ReqReady=0, outputs stable. Then i_RespReady=1 -> req1 is granted that cycle and its result appears the next cycle.
- Flush: FULL with i_RespReady=1, req0 valid and i_Flush=1 -> no grant, o_RespValid=0 next cycle, P unchanged. Re-presenting the request the following cycle is accepted.
- Reset mid-operation: deassert i_ResetN while FULL with o_RespId=1 -> all outputs are 0 immediately. After release, with both requesting, req0 is granted first.
- Saturation: hold 2'b11 for 65,540 cycles -> o_ConflictCount stops at 16'hFFFF and does not wrap.
